lcd_axis_timing: RTL
====================

# lcd_axis_timing

Single-clock LCD timing generator with an integrated AXI-Stream pixel FIFO, running entirely in the LCD pixel-clock domain. It replaces the fixed 480x272 driver-plus-controller pairing with one block that has:

- parametrised porch/sync timing;
- selectable RGB888/RGB565 input format;
- frame alignment on `tuser`;
- explicit underflow and line-length error reporting.

It sits between a pixel-clock-domain AXI-Stream source and the panel pins.

## Interface

Parameters:

- `H_ACTIVE`, 480, active pixels per line
- `H_FP`, 2, horizontal front porch, clocks
- `H_SYNC`, 41, hsync width, clocks
- `H_BP`, 2, horizontal back porch, clocks
- `V_ACTIVE`, 272, active lines per frame
- `V_FP`, 2, vertical front porch, lines
- `V_SYNC`, 10, vsync width, lines
- `V_BP`, 2, vertical back porch, lines
- `FIFO_DEPTH`, 16, pixel FIFO entries; power of two, ≥4
- `PIX_MODE`, 0, 0 = RGB888 from `tdata[23:0]`, 1 = RGB565 from `tdata[15:0]`

Ports:

- `clk` in 1 — pixel clock; the only clock
- `rst_n` in 1 — asynchronous, active-low reset
- `axis_tdata` in 32 — pixel word
- `axis_tvalid` in 1 — source beat valid
- `axis_tready` out 1 — block accepts the beat
- `axis_tuser` in 1 — start-of-frame marker on the first pixel
- `axis_tlast` in 1 — end-of-line marker on the last pixel of a line
- `lcd_hs` out 1 — hsync, active low
- `lcd_vs` out 1 — vsync, active low
- `lcd_de` out 1 — data enable
- `lcd_rgb` out 24 — pixel, {R,G,B}
- `lcd_xpos` out 11 — active column, 0 outside active
- `lcd_ypos` out 11 — active row, 0 outside active
- `frame_start` out 1 — one-clock pulse with the first active pixel of each frame
- `underflow` out 1 — one-clock pulse per active pixel output while the FIFO was empty in RUN
- `line_err` out 1 — one-clock pulse when `tlast` position ≠ beat `H_ACTIVE-1` of a line
- `resync` out 1 — one-clock pulse when an early/late `tuser` forces realignment
- `fifo_level` out $clog2(FIFO_DEPTH)+1 — current FIFO occupancy

## Operation

Timing counters:

- `h_cnt` runs 0..H_TOTAL-1, where H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; it wraps and then increments `v_cnt`.
- `v_cnt` runs 0..V_TOTAL-1, where V_TOTAL is defined likewise.
- Segment order on both axes: sync, back porch, active, front porch.
- hs low while `h_cnt` < `H_SYNC`; vs low while `v_cnt` < `V_SYNC`.
- active = both counters inside their active windows; `xpos` = `h_cnt`-(H_SYNC+H_BP), `ypos` likewise.

Ingress:

- `tready` = !full && state ≠ reset; a beat is taken when `tvalid`&&`tready`.
- `wr_pix` counts accepted beats in the current frame. `wr_col` counts accepted beats in the current line, wrapping at H_ACTIVE.
- `tlast` is checked on every accepted beat: `tlast` with `wr_col`≠H_ACTIVE-1, or no `tlast` with `wr_col`=H_ACTIVE-1, pulses `line_err`. Data is still stored; there is no correction.

State machine (reset → WAIT_SOF):

- **WAIT_SOF**: accepted beats are discarded unless `tuser`=1. A `tuser` beat is written to the FIFO, sets `wr_pix`=1, then → FILL.
- **FILL**: beats are written to the FIFO. At `h_cnt`=0 && `v_cnt`=0 → RUN.
- **RUN**: one FIFO pop per active pixel.
  - Empty at an active pixel: rgb=0, `underflow` pulses, and the pixel is not re-owed.
  - A `tuser` beat with `wr_pix`=H_ACTIVE*V_ACTIVE is a normal frame boundary: write it, `wr_pix`=1, stay in RUN.
  - A `tuser` beat with any other `wr_pix` pulses `resync`, flushes the FIFO, writes that beat, sets `wr_pix`=1, then → FILL.
- Outside RUN: `lcd_de` still follows the timing, rgb=0, no pops.

Pixel format:

- PIX_MODE=0: rgb = `tdata[23:0]`.
- PIX_MODE=1: rgb = {d[15:11],d[15:13], d[10:5],d[10:9], d[4:0],d[4:2]} (MSB replication).

FIFO boundary rules:

- Flush and push in the same cycle: the FIFO holds only the pushed beat.
- Flush and pop in the same cycle: flush wins.
- Push and pop in the same cycle when not full: level unchanged.
- Pointers wrap modulo FIFO_DEPTH; `fifo_level` ≤ FIFO_DEPTH.

## Timing

- Reset values: hs=1, vs=1, de=0, rgb=0, xpos=0, ypos=0, frame_start=0, underflow=0, line_err=0, resync=0, tready=0, fifo_level=0, h_cnt=v_cnt=0, state=WAIT_SOF.
- `tready` rises on the first clock edge after `rst_n` deasserts.
- Deassertion of `rst_n` mid-frame restarts the timing at `h_cnt`=`v_cnt`=0 and discards FIFO content.
- All lcd_* outputs, `frame_start` and `underflow` are registered from the current counters and the FIFO read port (combinational read), so they lag the counters by exactly 1 clock and stay mutually aligned.
- Pixel latency in RUN: a beat written at cycle t is eligible for pop at t+1.
- `line_err` and `resync` are registered and pulse 1 clock after the offending beat.
- `fifo_level` updates 1 clock after a push, pop or flush.

## Test plan

Small timing used throughout: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), FIFO_DEPTH=4.

- **Reset/timing:** free-running with no stream for 2 frames → hs low 2 of every 8 clocks, vs low 8 clocks per 48, de high 12 clocks/frame, rgb=0, no underflow (state ≠ RUN).
- **Normal frame:** `tuser` on beat 0, `tlast` on beats 3/7/11, data 0x000001..0x00000C, `tvalid` held high → rgb equals 0x000001..0x00000C in raster order, xpos 0..3, ypos 0..2, one `frame_start`, no error pulses.
- **RGB565:** PIX_MODE=1, tdata=0xF800 → rgb=0xFF0000; tdata=0x07E0 → 0x00FF00; tdata=0x0841 → 0x080808.
- **Underflow:** in RUN, stop `tvalid` after 5 beats → pixels 6..12 output 0, 7 `underflow` pulses; backpressure check: `tready`=0 while fifo_level=4.
- **Resync:** `tuser` arrives at `wr_pix`=7 → `resync` pulses once, `fifo_level`=1 next clock, state returns to RUN at the next `h_cnt`=`v_cnt`=0, and the following frame displays the new data.
- **Line error:** `tlast` on beat 2 of line 0 → exactly one `line_err` pulse; a missing `tlast` on beat 7 → one more pulse; pixel data is unaffected.

Source files
------------

// File: rtl/lcd_axis_timing.sv
// LCD timing generator with an integrated AXI-Stream pixel FIFO.
// Everything runs on the pixel clock. Raster counters drive sync/DE,
// and a small FIFO decouples the stream source from the panel raster.
// Frames are aligned on tuser. Underflow, line-length and realignment
// events are reported as single-clock pulses.
module lcd_axis_timing #(
    parameter int H_ACTIVE   = 480,
    parameter int H_FP       = 2,
    parameter int H_SYNC     = 41,
    parameter int H_BP       = 2,
    parameter int V_ACTIVE   = 272,
    parameter int V_FP       = 2,
    parameter int V_SYNC     = 10,
    parameter int V_BP       = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int PIX_MODE   = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   axis_tdata,
    input  logic                          axis_tvalid,
    output logic                          axis_tready,
    input  logic                          axis_tuser,
    input  logic                          axis_tlast,
    output logic                          lcd_hs,
    output logic                          lcd_vs,
    output logic                          lcd_de,
    output logic [23:0]                   lcd_rgb,
    output logic [10:0]                   lcd_xpos,
    output logic [10:0]                   lcd_ypos,
    output logic                          frame_start,
    output logic                          underflow,
    output logic                          line_err,
    output logic                          resync,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int CW      = 12;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = AW + 1;
    localparam int PW      = $clog2(H_ACTIVE * V_ACTIVE + 1) + 2;

    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_C  = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_C  = CW'(V_SYNC);
    localparam logic [CW-1:0] H_ACT_LO  = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] H_ACT_HI  = CW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_LO  = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] V_ACT_HI  = CW'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [CW-1:0] COL_LAST  = CW'(H_ACTIVE - 1);
    localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
    localparam logic [PW-1:0] FRAME_PIX = PW'(H_ACTIVE * V_ACTIVE);

    typedef enum logic [1:0] {
        ST_WAIT_SOF,
        ST_FILL,
        ST_RUN
    } state_t;

    // Expand the stream word to 24-bit {R,G,B}; RGB565 widens by MSB replication.
    function automatic logic [23:0] pix_convert(input logic [23:0] d);
        if (PIX_MODE == 1)
            return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
        else
            return d;
    endfunction

    logic [CW-1:0] h_cnt, v_cnt;
    state_t        state, state_nxt;
    logic          rdy_en;
    logic [23:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] fifo_cnt;
    logic [PW-1:0] wr_pix, wr_pix_nxt;
    logic [CW-1:0] wr_col, beat_col;
    logic          full, empty, accept, active, run_pix;
    logic          push, pop, flush, resync_nxt, line_err_nxt;
    logic [23:0]   rd_data;
    logic          unused_bits;

    logic          hs_p1, vs_p1, vld_p1, fs_p1, uf_p1;
    logic [23:0]   rgb_p1;
    logic [10:0]   xpos_p1, ypos_p1;
    logic          line_err_p1, resync_p1;

    assign unused_bits = ^axis_tdata[31:24];
    assign full        = (fifo_cnt == FULL_LVL);
    assign empty       = (fifo_cnt == '0);
    assign axis_tready = rdy_en && !full;
    assign accept      = axis_tvalid && axis_tready;
    assign active      = (h_cnt >= H_ACT_LO) && (h_cnt < H_ACT_HI) &&
                         (v_cnt >= V_ACT_LO) && (v_cnt < V_ACT_HI);
    assign run_pix     = (state == ST_RUN) && active;
    assign rd_data     = mem[rd_ptr];
    // A start-of-frame beat is column 0 by definition, whatever came before.
    assign beat_col    = axis_tuser ? '0 : wr_col;

    // Raster counters: h wraps every line and then steps v.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Ingress decisions: frame alignment, FIFO push/pop/flush and error flags.
    always_comb begin
        state_nxt    = state;
        wr_pix_nxt   = wr_pix;
        push         = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;
        resync_nxt   = 1'b0;
        line_err_nxt = accept && (axis_tlast != (beat_col == COL_LAST));
        case (state)
            ST_WAIT_SOF: begin
                if (accept && axis_tuser) begin
                    push       = 1'b1;
                    wr_pix_nxt = PW'(1);
                    state_nxt  = ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    push       = 1'b1;
                    wr_pix_nxt = axis_tuser ? PW'(1) : wr_pix + 1'b1;
                end
                if (h_cnt == '0 && v_cnt == '0)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                pop = active && !empty;
                if (accept) begin
                    push = 1'b1;
                    if (axis_tuser) begin
                        wr_pix_nxt = PW'(1);
                        if (wr_pix != FRAME_PIX) begin
                            resync_nxt = 1'b1;
                            flush      = 1'b1;
                            state_nxt  = ST_FILL;
                        end
                    end else begin
                        wr_pix_nxt = wr_pix + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_WAIT_SOF;
        endcase
    end

    // Control state: FSM, ingress counters, ready enable and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_WAIT_SOF;
            rdy_en      <= 1'b0;
            wr_pix      <= '0;
            wr_col      <= '0;
            line_err_p1 <= 1'b0;
            resync_p1   <= 1'b0;
        end else begin
            state       <= state_nxt;
            rdy_en      <= 1'b1;
            wr_pix      <= wr_pix_nxt;
            line_err_p1 <= line_err_nxt;
            resync_p1   <= resync_nxt;
            if (accept)
                wr_col <= (beat_col == COL_LAST) ? '0 : beat_col + 1'b1;
        end
    end

    // FIFO pointers and occupancy; a flush leaves only the beat pushed with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            rd_ptr   <= wr_ptr;
            wr_ptr   <= wr_ptr + 1'b1;
            fifo_cnt <= LW'(1);
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fifo_cnt <= fifo_cnt + 1'b1;
            else if (pop && !push)
                fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    // FIFO storage holds converted pixels; data needs no reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= pix_convert(axis_tdata[23:0]);
    end

    // Panel output stage: registered from current counters and FIFO head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_p1   <= 1'b1;
            vs_p1   <= 1'b1;
            vld_p1  <= 1'b0;
            rgb_p1  <= '0;
            xpos_p1 <= '0;
            ypos_p1 <= '0;
            fs_p1   <= 1'b0;
            uf_p1   <= 1'b0;
        end else begin
            hs_p1   <= (h_cnt >= H_SYNC_C);
            vs_p1   <= (v_cnt >= V_SYNC_C);
            vld_p1  <= active;
            rgb_p1  <= (run_pix && !empty) ? rd_data : '0;
            xpos_p1 <= active ? 11'(h_cnt - H_ACT_LO) : '0;
            ypos_p1 <= active ? 11'(v_cnt - V_ACT_LO) : '0;
            fs_p1   <= run_pix && (h_cnt == H_ACT_LO) && (v_cnt == V_ACT_LO);
            uf_p1   <= run_pix && empty;
        end
    end

    assign lcd_hs      = hs_p1;
    assign lcd_vs      = vs_p1;
    assign lcd_de      = vld_p1;
    assign lcd_rgb     = rgb_p1;
    assign lcd_xpos    = xpos_p1;
    assign lcd_ypos    = ypos_p1;
    assign frame_start = fs_p1;
    assign underflow   = uf_p1;
    assign line_err    = line_err_p1;
    assign resync      = resync_p1;
    assign fifo_level  = fifo_cnt;

endmodule
